// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the ALU issue controller.
package alu_pkg;
    typedef enum logic [6:0] {
        OP_ADD = 7'd1,
        OP_SUB = 7'd2,
        OP_MUL = 7'd3,
        OP_DIV = 7'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } issue_state_e;

    localparam int REG_ZERO = 0;

    function automatic logic is_legal_op(input logic [6:0] op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV};
    endfunction
endpackage

// File: rtl/alu_fwd_tag.sv
// alu_fwd_tag: forwarding tag (last completed rd) with source-register comparators.
// Matches look at the tag value being written this cycle so an op accepted on the done cycle sees it.
module alu_fwd_tag
    import alu_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [REG_AW-1:0] load_tag,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    output logic              match1,
    output logic              match2
);
    logic [REG_AW-1:0] tag_q, tag_d;
    logic              valid_q, valid_d;

    always_comb begin
        tag_d   = load ? load_tag : tag_q;
        valid_d = load ? (load_tag != REG_AW'(REG_ZERO)) : clr ? 1'b0 : valid_q;
        match1  = valid_d && (rs1 == tag_d);
        match2  = valid_d && (rs2 == tag_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            tag_q   <= tag_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded ALU op at a time, drives operands/forwarding, writes result back.
// Define ALU_FWD_EN to merge writeback into EXEC and enable es/M forwarding controls.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    output logic [REG_AW-1:0] rf_raddr1,
    output logic [REG_AW-1:0] rf_raddr2,
    input  logic [31:0]       rf_rdata1,
    input  logic [31:0]       rf_rdata2,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [31:0]       alu_rs1,
    output logic [31:0]       alu_rs2,
    output logic [6:0]        alu_oper,
    output logic              sig_es1,
    output logic              sig_es2,
    output logic              sig_M1,
    output logic              sig_M2,
    input  logic [31:0]       alu_res,
    input  logic              alu_done,
    output logic              err
);
    localparam int TW = $clog2(TIMEOUT);
`ifdef ALU_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif
    localparam logic [REG_AW-1:0] ZR = REG_AW'(REG_ZERO);

    issue_state_e      state_q, state_d;
    logic [REG_AW-1:0] rd_q, rd_d;
    logic [31:0]       alu_rs1_q, alu_rs1_d, alu_rs2_q, alu_rs2_d, res_q, res_d;
    logic [6:0]        oper_q, oper_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              err_q, err_d, m1_q, m1_d, m2_q, m2_d;
    logic              exec, done, tmo, accept, issue, match1, match2;

    alu_fwd_tag #(.REG_AW(REG_AW)) u_tag (
        .clk      (clk),
        .rst      (rst),
        .load     (done),
        .clr      (tmo),
        .load_tag (rd_q),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .match1   (match1),
        .match2   (match2)
    );

    always_comb begin
        exec      = state_q == S_EXEC;
        done      = exec && alu_done;
        tmo       = exec && !alu_done && (timer_q == TW'(TIMEOUT - 1));
        in_ready  = (state_q == S_IDLE) || (FWD && done);
        accept    = in_valid && in_ready;
        issue     = accept && is_legal_op(in_op);
        state_d   = issue ? S_EXEC : (done && !FWD) ? S_WB :
                    (done || tmo || state_q == S_WB) ? S_IDLE : state_q;
        timer_d   = issue ? '0 : exec ? timer_q + TW'(1) : timer_q;
        rd_d      = issue ? in_rd : rd_q;
        oper_d    = issue ? in_op : oper_q;
        alu_rs1_d = issue ? ((in_rs1 == ZR) ? 32'd0 : rf_rdata1) : alu_rs1_q;
        alu_rs2_d = issue ? ((in_rs2 == ZR) ? 32'd0 : rf_rdata2) : alu_rs2_q;
        res_d     = done ? alu_res : res_q;
        err_d     = (accept && !is_legal_op(in_op)) || tmo;
        m1_d      = issue ? match1 : m1_q;
        m2_d      = issue ? match2 : m2_q;
        rf_raddr1 = in_rs1;
        rf_raddr2 = in_rs2;
        rf_we     = (rd_q != ZR) && (FWD ? done : state_q == S_WB);
        rf_waddr  = rd_q;
        rf_wdata  = FWD ? alu_res : res_q;
        alu_rs1   = alu_rs1_q;
        alu_rs2   = alu_rs2_q;
        alu_oper  = oper_q;
        sig_es1   = FWD && done;
        sig_es2   = FWD && done;
        sig_M1    = FWD && exec && m1_q;
        sig_M2    = FWD && exec && m2_q;
        err       = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_q      <= '0;
            oper_q    <= '0;
            alu_rs1_q <= '0;
            alu_rs2_q <= '0;
            res_q     <= '0;
            timer_q   <= '0;
            err_q     <= 1'b0;
            m1_q      <= 1'b0;
            m2_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            oper_q    <= oper_d;
            alu_rs1_q <= alu_rs1_d;
            alu_rs2_q <= alu_rs2_d;
            res_q     <= res_d;
            timer_q   <= timer_d;
            err_q     <= err_d;
            m1_q      <= m1_d;
            m2_q      <= m2_d;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed bench for alu_issue_ctrl with a small register-file model.
// Expectations follow ALU_FWD_EN when it is defined for the build.
module tb_alu_issue_ctrl;
`ifdef ALU_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_ready;
    logic [6:0]  in_op = '0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
    logic [31:0] rf_rdata1, rf_rdata2, rf_wdata, alu_rs1, alu_rs2;
    logic        rf_we, sig_es1, sig_es2, sig_M1, sig_M2, err;
    logic [6:0]  alu_oper;
    logic [31:0] alu_res = '0;
    logic        alu_done = 1'b0;
    logic [31:0] rf_mem [32];
    int          we_count = 0;
    logic [4:0]  last_waddr = '0;
    logic [31:0] last_wdata = '0;
    int          checks = 0, failures = 0;

    alu_issue_ctrl #(.TIMEOUT(8), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .rf_raddr1(rf_raddr1),
        .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_oper(alu_oper), .sig_es1(sig_es1), .sig_es2(sig_es2), .sig_M1(sig_M1),
        .sig_M2(sig_M2), .alu_res(alu_res), .alu_done(alu_done), .err(err)
    );

    always #5 clk = ~clk;

    assign rf_rdata1 = rf_mem[rf_raddr1];
    assign rf_rdata2 = rf_mem[rf_raddr2];

    // x0 is seeded with garbage so the controller's hard-zero handling is visible
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                rf_mem[i] <= (i == 0) ? 32'hDEAD_BEEF : (i == 1) ? 32'd3 : (i == 2) ? 32'd1 :
                             (i == 6) ? 32'd1 : 32'd0;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
            we_count   <= we_count + 1;
            last_waddr <= rf_waddr;
            last_wdata <= rf_wdata;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] rd, rs1, rs2);
        int n = 0;
        in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        #1;
        while (!in_ready && n < 10) begin tick; n++; end
        checks++;
        if (n >= 10) begin failures++; $display("FAIL issue_wait: in_ready=%b required 1", in_ready); end
        tick;
        in_valid = 1'b0;
    endtask

    task automatic finish_op(input logic [31:0] r);
        int n = 0;
        alu_done = 1'b1; alu_res = r;
        tick;
        alu_done = 1'b0;
        #1;
        while (!in_ready && n < 10) begin tick; n++; end
        checks++;
        if (n >= 10) begin failures++; $display("FAIL finish_wait: in_ready=%b required 1", in_ready); end
    endtask

    task automatic test_reset;
        tick; tick;
        checks += 4;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", in_ready); end
        if ({rf_we, err, sig_es1, sig_es2, sig_M1, sig_M2} !== 6'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 000000", {rf_we, err, sig_es1, sig_es2, sig_M1, sig_M2});
        end
        if ({alu_rs1, alu_rs2} !== 64'd0) begin failures++; $display("FAIL reset_ops: got %h %h want 0 0", alu_rs1, alu_rs2); end
        if (alu_oper !== 7'd0) begin failures++; $display("FAIL reset_oper: got %0d want 0", alu_oper); end
        rst = 1'b0;
    endtask

    task automatic test_add;
        int wc = we_count;
        in_valid = 1'b1; in_op = 7'd1; in_rd = 5'd3; in_rs1 = 5'd1; in_rs2 = 5'd2;
        #1;
        checks++;
        if ({rf_raddr1, rf_raddr2} !== {5'd1, 5'd2}) begin
            failures++; $display("FAIL add_raddr: got %0d %0d want 1 2", rf_raddr1, rf_raddr2);
        end
        tick;
        in_valid = 1'b0;
        checks += 2;
        if ({alu_rs1, alu_rs2, alu_oper} !== {32'd3, 32'd1, 7'd1}) begin
            failures++; $display("FAIL add_operands: got %0d %0d %0d want 3 1 1", alu_rs1, alu_rs2, alu_oper);
        end
        if (in_ready !== 1'b0) begin failures++; $display("FAIL add_busy: in_ready=%b want 0", in_ready); end
        tick;
        alu_done = 1'b1; alu_res = 32'd4;
        #1;
        checks += 2;
        if (rf_we !== FWD) begin failures++; $display("FAIL add_we_done: got %b want %b", rf_we, FWD); end
        if (sig_es1 !== FWD) begin failures++; $display("FAIL add_es_done: got %b want %b", sig_es1, FWD); end
        tick;
        alu_done = 1'b0;
        #1;
        checks++;
        if (rf_we !== !FWD) begin failures++; $display("FAIL add_we_wb: got %b want %b", rf_we, !FWD); end
        tick;
        checks += 2;
        if ({we_count - wc, last_waddr, last_wdata} !== {32'd1, 5'd3, 32'd4}) begin
            failures++; $display("FAIL add_write: count=%0d addr=%0d data=%0d want 1 3 4", we_count - wc, last_waddr, last_wdata);
        end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL add_idle: in_ready=%b want 1", in_ready); end
    endtask

    task automatic test_back_to_back;
        int n = 0;
        issue(7'd1, 5'd5, 5'd1, 5'd2);
        alu_done = 1'b1; alu_res = 32'd4;
        in_valid = 1'b1; in_op = 7'd2; in_rd = 5'd7; in_rs1 = 5'd5; in_rs2 = 5'd6;
        #1;
        checks += 2;
        if ({sig_es1, sig_es2} !== {FWD, FWD}) begin
            failures++; $display("FAIL b2b_es: got %b%b want %b%b", sig_es1, sig_es2, FWD, FWD);
        end
        if (in_ready !== FWD) begin failures++; $display("FAIL b2b_ready_done: got %b want %b", in_ready, FWD); end
        while (!in_ready && n < 10) begin tick; alu_done = 1'b0; #1; n++; end
        tick;
        alu_done = 1'b0; in_valid = 1'b0;
        checks += 4;
        if (n !== (FWD ? 0 : 2)) begin failures++; $display("FAIL b2b_bubbles: got %0d want %0d", n, FWD ? 0 : 2); end
        if ({sig_M1, sig_M2} !== {FWD, 1'b0}) begin
            failures++; $display("FAIL b2b_fwd: M1M2=%b%b want %b0", sig_M1, sig_M2, FWD);
        end
        if (alu_oper !== 7'd2) begin failures++; $display("FAIL b2b_oper: got %0d want 2", alu_oper); end
        if (alu_rs2 !== 32'd1) begin failures++; $display("FAIL b2b_rs2: got %0d want 1", alu_rs2); end
`ifndef ALU_FWD_EN
        checks++;
        if (alu_rs1 !== 32'd4) begin failures++; $display("FAIL b2b_rs1_rf: got %0d want 4", alu_rs1); end
`endif
        finish_op(32'd3);
        checks++;
        if ({last_waddr, last_wdata} !== {5'd7, 32'd3}) begin
            failures++; $display("FAIL b2b_write: addr=%0d data=%0d want 7 3", last_waddr, last_wdata);
        end
    endtask

    task automatic test_x0;
        int wc;
        issue(7'd1, 5'd0, 5'd1, 5'd2);
        wc = we_count;
        finish_op(32'd4);
        tick;
        checks++;
        if (we_count !== wc) begin failures++; $display("FAIL x0_nowrite: writes=%0d want 0", we_count - wc); end
        issue(7'd1, 5'd8, 5'd0, 5'd1);
        checks += 2;
        if ({alu_rs1, alu_rs2} !== {32'd0, 32'd3}) begin
            failures++; $display("FAIL x0_read: got %h %0d want 0 3", alu_rs1, alu_rs2);
        end
        if ({sig_M1, sig_M2} !== 2'b00) begin failures++; $display("FAIL x0_fwd: got %b%b want 00", sig_M1, sig_M2); end
        finish_op(32'd3);
    endtask

    task automatic test_timeout;
        int wc = we_count;
        int n = 0;
        issue(7'd3, 5'd9, 5'd1, 5'd2);
        while (!err && n < 20) begin tick; n++; end
        checks += 3;
        if (n !== 8) begin failures++; $display("FAIL tmo_cycles: got %0d want 8", n); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL tmo_ready: got %b want 1", in_ready); end
        if (we_count !== wc) begin failures++; $display("FAIL tmo_nowrite: writes=%0d want 0", we_count - wc); end
        tick;
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL tmo_pulse: err=%b want 0", err); end
    endtask

    task automatic test_illegal;
        int wc = we_count;
        in_valid = 1'b1; in_op = 7'h05; in_rd = 5'd10; in_rs1 = 5'd1; in_rs2 = 5'd2;
        tick;
        in_valid = 1'b0;
        checks += 3;
        if (err !== 1'b1) begin failures++; $display("FAIL ill_err: got %b want 1", err); end
        if (alu_oper !== 7'd3) begin failures++; $display("FAIL ill_oper: got %0d want 3", alu_oper); end
        if (in_ready !== 1'b1) begin failures++; $display("FAIL ill_idle: in_ready=%b want 1", in_ready); end
        tick;
        checks++;
        if ({err, in_ready} !== 2'b01) begin failures++; $display("FAIL ill_after: err,ready=%b want 01", {err, in_ready}); end
        alu_done = 1'b1; alu_res = 32'd99;
        tick;
        alu_done = 1'b0;
        tick;
        checks++;
        if ({we_count - wc, in_ready, err} !== {32'd0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL stray_done: writes=%0d ready=%b err=%b want 0 1 0", we_count - wc, in_ready, err);
        end
    endtask

    task automatic test_async_reset;
        int wc;
        issue(7'd4, 5'd11, 5'd1, 5'd2);
        checks++;
        if (alu_oper !== 7'd4) begin failures++; $display("FAIL rst_pre_oper: got %0d want 4", alu_oper); end
        #2 rst = 1'b1;
        #1;
        checks += 2;
        if ({in_ready, rf_we, sig_M1, err} !== 4'b1000) begin
            failures++; $display("FAIL rst_async_flags: got %b want 1000", {in_ready, rf_we, sig_M1, err});
        end
        if ({alu_rs1, alu_oper} !== 39'd0) begin failures++; $display("FAIL rst_async_regs: got %h %0d want 0 0", alu_rs1, alu_oper); end
        tick;
        rst = 1'b0;
        wc = we_count;
        alu_done = 1'b1; alu_res = 32'd7;
        tick;
        alu_done = 1'b0;
        tick; tick;
        checks++;
        if ({we_count - wc, in_ready} !== {32'd0, 1'b1}) begin
            failures++; $display("FAIL rst_nowrite: writes=%0d ready=%b want 0 1", we_count - wc, in_ready);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_back_to_back;
        test_x0;
        test_timeout;
        test_illegal;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
